// File: rtl/sync_pipe_pkg.sv
// Shared definitions for the sync_pipe retiming chain and the blocks that instantiate it.
package sync_pipe_pkg;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_pipe_stage.sv
// One register stage of sync_pipe: data register plus its valid bit.
module sync_pipe_stage
    import sync_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    // Data only moves on load; clear drops the valid but leaves the data in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
            v <= 1'b0;
        end else begin
            if (load) begin
                q <= d;
            end
            if (clear) begin
                v <= 1'b0;
            end else if (load) begin
                v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_pipe.sv
// Handshaked delay line of DEPTH stages; bubbles collapse toward a stalled output.
module sync_pipe
    import sync_pipe_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [occ_width(DEPTH)-1:0]    occupancy
);

    localparam int unsigned OW = occ_width(DEPTH);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            adv;
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            clear;
    logic [DEPTH-1:0][WIDTH-1:0] q;
    logic                        accept;
    logic                        pop;
    logic                        room;

    // A stage advances when it holds a word and there is a gap anywhere ahead of it,
    // or the whole run ahead drains through out_ready.
    always_comb begin
        adv  = '0;
        room = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i] = v[i] & room;
            room   = room | ~v[i];
        end
    end

    assign in_ready = ~flush & (~v[0] | adv[0]);
    assign accept   = in_valid & in_ready;
    assign pop      = v[DEPTH-1] & out_ready;

    // Stage i+1 loads from stage i; a stage that empties without a refill drops its valid.
    always_comb begin
        load  = ((adv << 1) | DEPTH'(accept)) & ~{DEPTH{flush}};
        clear = {DEPTH{flush}} | (adv & ~load);
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
        logic [WIDTH-1:0] d;
        if (i == 0) begin : g_head
            assign d = in_data;
        end else begin : g_body
            assign d = q[i-1];
        end

        sync_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .load  (load[i]),
            .clear (clear[i]),
            .d     (d),
            .q     (q[i]),
            .v     (v[i])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = q[DEPTH-1];

    // Word count tracks accepts and output transfers; a simultaneous push/pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (accept && !pop) begin
            occupancy <= occupancy + OW'(1);
        end else if (pop && !accept) begin
            occupancy <= occupancy - OW'(1);
        end
    end

endmodule

// File: tb/tb_sync_pipe.sv
// Bench for sync_pipe: a DEPTH=4/WIDTH=8 and a DEPTH=1/WIDTH=1 build checked against a word-list model.
module tb_sync_pipe;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;

    logic       in_ready4, out_valid4;
    logic [7:0] out_data4;
    logic [2:0] occ4;
    logic       in_ready1, out_valid1;
    logic [0:0] out_data1;
    logic [0:0] occ1;
    logic [0:0] in_data1;

    assign in_data1 = in_data[0:0];

    sync_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hC3)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .occupancy(occ4)
    );

    sync_pipe #(.WIDTH(1), .DEPTH(1), .RST_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each build holds an ordered word list (oldest first) with each word's stage index.
    int         dep   [2];
    logic [7:0] mask  [2];
    logic [7:0] rstv  [2];
    logic [7:0] mdat  [2][4];
    int         mpos  [2][4];
    int         mcnt  [2];
    logic [7:0] mlast [2];
    bit         started = 1'b0;

    // A word moves up if a free slot exists anywhere ahead of it, or the output drains.
    function automatic bit m_adv(input int m, input int k, input bit ordy);
        return ordy || (k < dep[m] - 1 - mpos[m][k]);
    endfunction

    function automatic bit m_out_valid(input int m);
        return (mcnt[m] > 0) && (mpos[m][0] == dep[m] - 1);
    endfunction

    function automatic bit m_in_ready(input int m, input bit f, input bit ordy);
        if (f) return 1'b0;
        if (mcnt[m] == 0) return 1'b1;
        if (mpos[m][mcnt[m]-1] != 0) return 1'b1;
        return m_adv(m, mcnt[m] - 1, ordy);
    endfunction

    task automatic m_tick(input int m, input bit r, input bit f, input bit iv,
                          input logic [7:0] id, input bit ordy);
        bit acc, pop;
        bit mv [4];
        if (r) begin
            mcnt[m]  = 0;
            mlast[m] = rstv[m];
            return;
        end
        if (f) begin
            mcnt[m] = 0;
            return;
        end
        acc = iv && m_in_ready(m, f, ordy);
        pop = m_out_valid(m) && ordy;
        for (int k = 0; k < mcnt[m]; k++) mv[k] = m_adv(m, k, ordy);
        for (int k = 0; k < mcnt[m]; k++) if (mv[k]) mpos[m][k]++;
        if (pop) begin
            for (int k = 0; k < mcnt[m] - 1; k++) begin
                mdat[m][k] = mdat[m][k+1];
                mpos[m][k] = mpos[m][k+1];
            end
            mcnt[m]--;
        end
        if (acc) begin
            mdat[m][mcnt[m]] = id & mask[m];
            mpos[m][mcnt[m]] = 0;
            mcnt[m]++;
        end
        for (int k = 0; k < mcnt[m]; k++)
            if (mpos[m][k] == dep[m] - 1) mlast[m] = mdat[m][k];
    endtask

    logic       obs_ir, obs_ov;
    logic [7:0] obs_od;
    logic [2:0] obs_occ;

    // Drive one cycle, compare both builds before the edge, then advance the model.
    task automatic step(input bit r, input bit f, input bit iv, input logic [7:0] id, input bit ordy);
        rst = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        if (started) begin
            check("d4_in_ready",  32'(in_ready4),  32'(m_in_ready(0, f, ordy)));
            check("d4_out_valid", 32'(out_valid4), 32'(m_out_valid(0)));
            check("d4_out_data",  32'(out_data4),  32'(mlast[0]));
            check("d4_occupancy", 32'(occ4),       32'(mcnt[0]));
            check("d1_in_ready",  32'(in_ready1),  32'(m_in_ready(1, f, ordy)));
            check("d1_out_valid", 32'(out_valid1), 32'(m_out_valid(1)));
            check("d1_out_data",  32'(out_data1),  32'(mlast[1]));
            check("d1_occupancy", 32'(occ1),       32'(mcnt[1]));
        end
        obs_ir = in_ready4; obs_ov = out_valid4; obs_od = out_data4; obs_occ = occ4;
        @(posedge clk);
        m_tick(0, r, f, iv, id, ordy);
        m_tick(1, r, f, iv, id, ordy);
        if (r) started = 1'b1;
        #1;
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        dep[0] = 4;  mask[0] = 8'hFF; rstv[0] = 8'hC3;
        dep[1] = 1;  mask[1] = 8'h01; rstv[1] = 8'h01;
        mcnt[0] = 0; mcnt[1] = 0;

        // Reset held two cycles with a word offered.
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_out_valid", 32'(obs_ov),  32'd0);
        check("rst_out_data",  32'(obs_od),  32'hC3);
        check("rst_occupancy", 32'(obs_occ), 32'd0);
        check("rst_in_ready",  32'(obs_ir),  32'd1);

        // Back-to-back stream through the empty pipe.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, i < 8, 8'(i + 1), 1'b1);
            if (i == 3) check("lat_early", 32'(obs_ov), 32'd0);
            if (i == 4) begin
                check("lat_valid", 32'(obs_ov),  32'd1);
                check("lat_data",  32'(obs_od),  32'h01);
                check("lat_occ",   32'(obs_occ), 32'd4);
            end
            if (i == 5) check("stream_next", 32'(obs_od), 32'h02);
        end
        drain();

        // Fill against a stalled output, then push and pop in the same cycle.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h14, 1'b0);
        check("full_in_ready", 32'(obs_ir),  32'd0);
        check("full_occ",      32'(obs_occ), 32'd4);
        check("full_data",     32'(obs_od),  32'h10);
        step(1'b0, 1'b0, 1'b1, 8'h14, 1'b1);
        check("pushpop_in_ready", 32'(obs_ir), 32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("pushpop_occ",  32'(obs_occ), 32'd4);
        check("pushpop_data", 32'(obs_od),  32'h11);
        drain();

        // Bubble collapse behind a stall.
        step(1'b0, 1'b0, 1'b1, 8'h20, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h21, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("bubble_occ",   32'(obs_occ), 32'd2);
        check("bubble_first", 32'(obs_od),  32'h20);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("bubble_second_v", 32'(obs_ov), 32'd1);
        check("bubble_second",   32'(obs_od), 32'h21);
        drain();

        // Flush with three words in flight and a word offered.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        check("flush_in_ready", 32'(obs_ir), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        check("flush_out_valid", 32'(obs_ov),  32'd0);
        check("flush_occ",       32'(obs_occ), 32'd0);
        check("flush_accept",    32'(obs_ir),  32'd1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("flush_after_occ", 32'(obs_occ), 32'd1);
        drain();

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 97) == 0, ($urandom % 13) == 0, ($urandom % 4) != 0,
                 8'($urandom), ((n / 40) % 3 == 2) ? (($urandom % 5) == 0) : (($urandom % 3) != 0));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
